ram_sp_sync_be_clr: RTL and testbench

Parametrised single-port synchronous RAM, the successor to the fixed 16 x 8 single-port RAM. Adds:
- configurable width and depth
- per-byte write enables
- an explicit read strobe with a valid flag
- selectable read-during-write behaviour
- an optional output register
- a sequential clear engine that sweeps every location to INIT_VALUE after reset or on request

Used as a scratch or buffer memory wherever the design needs deterministic contents after reset.

---
 rtl/ram_sp_sync_be_clr_pkg.sv | 14 +
 rtl/ram_sp_be_core.sv | 48 ++++
 rtl/ram_sp_sync_be_clr.sv | 154 +++++++++++++++
 tb/tb_ram_sp_sync_be_clr.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_sp_sync_be_clr_pkg.sv
// Shared constants and types for the byte-enable RAM with clear engine.
package ram_sp_sync_be_clr_pkg;

  // Same-address read-during-write policy.
  localparam int unsigned RdwReadFirst  = 0;
  localparam int unsigned RdwWriteFirst = 1;

  // Clear engine state.
  typedef enum logic {
    StIdle  = 1'b0,
    StClear = 1'b1
  } clr_state_e;

endpackage

// File: rtl/ram_sp_be_core.sv
// Storage array with per-lane writes and a read port that applies the
// read-during-write policy. No reset: contents are defined by the parent's
// clear sweep.
module ram_sp_be_core
  import ram_sp_sync_be_clr_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned BYTE_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned RDW_MODE   = RdwReadFirst
) (
  input  logic                             clk_i,
  input  logic [ADDR_WIDTH-1:0]            addr_i,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] we_i,
  input  logic [DATA_WIDTH-1:0]            wdata_i,
  output logic [DATA_WIDTH-1:0]            rdata_o
);

  localparam int unsigned NumLanes = DATA_WIDTH / BYTE_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] old_word;
  logic [DATA_WIDTH-1:0] merged_word;

  // Lane-masked write into the addressed word.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < NumLanes; k++) begin
      if (we_i[k]) begin
        mem_q[addr_i][k*BYTE_WIDTH +: BYTE_WIDTH] <= wdata_i[k*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  // Current word and the word as it will look after this cycle's write.
  always_comb begin
    old_word    = mem_q[addr_i];
    merged_word = old_word;
    for (int k = 0; k < NumLanes; k++) begin
      if (we_i[k]) begin
        merged_word[k*BYTE_WIDTH +: BYTE_WIDTH] = wdata_i[k*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  assign rdata_o = (RDW_MODE == RdwWriteFirst) ? merged_word : old_word;

endmodule

// File: rtl/ram_sp_sync_be_clr.sv
// Single-port synchronous RAM with byte enables, read strobe/valid,
// optional output register and a sequential clear engine that sweeps every
// word to INIT_VALUE after reset or on request.
module ram_sp_sync_be_clr
  import ram_sp_sync_be_clr_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 16,
  parameter int unsigned           BYTE_WIDTH = 8,
  parameter int unsigned           ADDR_WIDTH = 4,
  parameter int unsigned           DEPTH      = 16,
  parameter int unsigned           RDW_MODE   = 0,
  parameter int unsigned           OUT_REG    = 0,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DATA_WIDTH-1:0]            data_in,
  input  logic [ADDR_WIDTH-1:0]            address,
  input  logic                             write_en,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] byte_en,
  input  logic                             read_en,
  input  logic                             clear_req,
  output logic [DATA_WIDTH-1:0]            data_out,
  output logic                             data_valid,
  output logic                             busy
);

  localparam int unsigned           NumLanes = DATA_WIDTH / BYTE_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DepthExt = (ADDR_WIDTH + 1)'(DEPTH);

  clr_state_e            state_q;
  logic [ADDR_WIDTH-1:0] clr_addr_q;

  logic                  addr_in_range;
  logic                  access_ok;
  logic                  rd_accept;
  logic [ADDR_WIDTH-1:0] core_addr;
  logic [NumLanes-1:0]   core_we;
  logic [DATA_WIDTH-1:0] core_wdata;
  logic [DATA_WIDTH-1:0] core_rdata;
  logic [DATA_WIDTH-1:0] rd_word;

  logic [DATA_WIDTH-1:0] data_out_q;
  logic                  data_valid_q;

  assign busy          = (state_q == StClear);
  assign addr_in_range = ({1'b0, address} < DepthExt);
  // clear_req wins over a same-cycle access; nothing is accepted during reset.
  assign access_ok     = (state_q == StIdle) && !rst && !clear_req;
  assign rd_accept     = access_ok && read_en;

  // Clear FSM: sweep clr_addr from 0 to DEPTH-1, then accept accesses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StClear;
      clr_addr_q <= '0;
    end else begin
      unique case (state_q)
        StClear: begin
          if (clr_addr_q == LastAddr) begin
            state_q    <= StIdle;
            clr_addr_q <= '0;
          end else begin
            clr_addr_q <= clr_addr_q + 1'b1;
          end
        end
        StIdle: begin
          if (clear_req) begin
            state_q    <= StClear;
            clr_addr_q <= '0;
          end
        end
        default: begin
          state_q    <= StClear;
          clr_addr_q <= '0;
        end
      endcase
    end
  end

  // Steer the single array port between the clear engine and user writes.
  always_comb begin
    core_addr  = address;
    core_wdata = data_in;
    core_we    = '0;
    if (rst) begin
      core_we = '0;
    end else if (busy) begin
      core_addr  = clr_addr_q;
      core_wdata = INIT_VALUE;
      core_we    = '1;
    end else if (access_ok && write_en && addr_in_range) begin
      core_we = byte_en;
    end
  end

  ram_sp_be_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .BYTE_WIDTH (BYTE_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH),
    .RDW_MODE   (RDW_MODE)
  ) u_core (
    .clk_i   (clk),
    .addr_i  (core_addr),
    .we_i    (core_we),
    .wdata_i (core_wdata),
    .rdata_o (core_rdata)
  );

  // Out-of-range reads return the clear value rather than array garbage.
  assign rd_word = addr_in_range ? core_rdata : INIT_VALUE;

  if (OUT_REG != 0) begin : g_out_reg
    logic                  s1_valid_q;
    logic [DATA_WIDTH-1:0] s1_data_q;

    // Two-stage read pipeline; data_out only loads alongside a valid.
    always_ff @(posedge clk) begin
      if (rst) begin
        s1_valid_q   <= 1'b0;
        data_valid_q <= 1'b0;
        data_out_q   <= '0;
      end else begin
        s1_valid_q   <= rd_accept;
        data_valid_q <= s1_valid_q;
        if (rd_accept) begin
          s1_data_q <= rd_word;
        end
        if (s1_valid_q) begin
          data_out_q <= s1_data_q;
        end
      end
    end
  end else begin : g_no_out_reg
    // Single-stage read; data_out holds the last read result.
    always_ff @(posedge clk) begin
      if (rst) begin
        data_valid_q <= 1'b0;
        data_out_q   <= '0;
      end else begin
        data_valid_q <= rd_accept;
        if (rd_accept) begin
          data_out_q <= rd_word;
        end
      end
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;

endmodule

// File: tb/tb_ram_sp_sync_be_clr.sv
// Bench for ram_sp_sync_be_clr: two instances with different configurations
// share one stimulus stream and are compared every cycle against a
// word-array reference model.
module tb_ram_sp_sync_be_clr;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 4;
  localparam int unsigned NB = 2;

  // Per-instance configuration: [0] = dut_a, [1] = dut_b.
  localparam int          PDepth [2] = '{16, 12};
  localparam int          PRdw   [2] = '{0, 1};
  localparam int          POreg  [2] = '{0, 1};
  localparam logic [15:0] PInit  [2] = '{16'h0000, 16'h5A5A};

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] data_in;
  logic [AW-1:0] address;
  logic          write_en;
  logic [NB-1:0] byte_en;
  logic          read_en;
  logic          clear_req;

  logic [DW-1:0] a_data_out, b_data_out;
  logic          a_valid, b_valid, a_busy, b_busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ram_sp_sync_be_clr #(
    .DATA_WIDTH (16), .BYTE_WIDTH (8), .ADDR_WIDTH (4), .DEPTH (16),
    .RDW_MODE (0), .OUT_REG (0), .INIT_VALUE (16'h0000)
  ) dut_a (
    .clk (clk), .rst (rst), .data_in (data_in), .address (address),
    .write_en (write_en), .byte_en (byte_en), .read_en (read_en),
    .clear_req (clear_req), .data_out (a_data_out), .data_valid (a_valid),
    .busy (a_busy)
  );

  ram_sp_sync_be_clr #(
    .DATA_WIDTH (16), .BYTE_WIDTH (8), .ADDR_WIDTH (4), .DEPTH (12),
    .RDW_MODE (1), .OUT_REG (1), .INIT_VALUE (16'h5A5A)
  ) dut_b (
    .clk (clk), .rst (rst), .data_in (data_in), .address (address),
    .write_en (write_en), .byte_en (byte_en), .read_en (read_en),
    .clear_req (clear_req), .data_out (b_data_out), .data_valid (b_valid),
    .busy (b_busy)
  );

  // Reference model state.
  logic [15:0] m_mem   [2][16];
  int          m_busy  [2];   // clear edges still to come
  logic        m_s1v   [2];
  logic [15:0] m_s1d   [2];
  logic        m_ov    [2];
  logic [15:0] m_od    [2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Apply one rising edge's worth of behaviour to the model.
  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      logic        rv;
      logic [15:0] rd;
      logic [15:0] old_w;
      logic [15:0] new_w;
      logic        in_rng;
      rv     = 1'b0;
      rd     = 16'h0;
      in_rng = int'(address) < PDepth[d];
      if (rst) begin
        m_busy[d] = PDepth[d];
        m_ov[d]   = 1'b0;
        m_od[d]   = 16'h0;
        m_s1v[d]  = 1'b0;
      end else begin
        if (m_busy[d] > 0) begin
          m_mem[d][PDepth[d] - m_busy[d]] = PInit[d];
          m_busy[d]--;
        end else if (clear_req) begin
          m_busy[d] = PDepth[d];
        end else begin
          old_w = in_rng ? m_mem[d][address] : PInit[d];
          new_w = old_w;
          if (byte_en[0]) new_w[7:0]  = data_in[7:0];
          if (byte_en[1]) new_w[15:8] = data_in[15:8];
          if (read_en) begin
            rv = 1'b1;
            if (!in_rng)                        rd = PInit[d];
            else if (write_en && PRdw[d] == 1) rd = new_w;
            else                                rd = old_w;
          end
          if (write_en && in_rng) m_mem[d][address] = new_w;
        end
        if (POreg[d] == 1) begin
          if (m_s1v[d]) m_od[d] = m_s1d[d];
          m_ov[d]  = m_s1v[d];
          m_s1v[d] = rv;
          m_s1d[d] = rd;
        end else begin
          m_ov[d] = rv;
          if (rv) m_od[d] = rd;
        end
      end
    end
  endtask

  // One clock: edge, model update, then sample both instances.
  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check_eq("a_busy",  32'(a_busy),     32'(m_busy[0] > 0));
    check_eq("a_valid", 32'(a_valid),    32'(m_ov[0]));
    check_eq("a_data",  32'(a_data_out), 32'(m_od[0]));
    check_eq("b_busy",  32'(b_busy),     32'(m_busy[1] > 0));
    check_eq("b_valid", 32'(b_valid),    32'(m_ov[1]));
    check_eq("b_data",  32'(b_data_out), 32'(m_od[1]));
  endtask

  task automatic count_busy(output int na, output int nb);
    na = -1;
    nb = -1;
    for (int n = 1; n <= 40; n++) begin
      cyc();
      if (na < 0 && !a_busy) na = n;
      if (nb < 0 && !b_busy) nb = n;
      if (na >= 0 && nb >= 0) break;
    end
  endtask

  task automatic idle_inputs();
    rst       = 1'b0;
    write_en  = 1'b0;
    read_en   = 1'b0;
    clear_req = 1'b0;
    byte_en   = 2'b00;
    data_in   = 16'h0;
    address   = 4'h0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
    idle_inputs();
    write_en = 1'b1;
    address  = a;
    data_in  = d;
    byte_en  = be;
    cyc();
  endtask

  initial begin
    int na, nb;
    for (int d = 0; d < 2; d++) begin
      m_busy[d] = 0;
      m_s1v[d]  = 1'b0;
      m_ov[d]   = 1'b0;
      m_od[d]   = 16'h0;
      m_s1d[d]  = 16'h0;
      for (int i = 0; i < 16; i++) m_mem[d][i] = 16'h0;
    end

    // 1. Reset, sweep length, everything reads as the clear value.
    idle_inputs();
    rst = 1'b1;
    repeat (3) cyc();
    rst = 1'b0;
    count_busy(na, nb);
    check_eq("t1_busy_len_a", 32'(na), 32'd16);
    check_eq("t1_busy_len_b", 32'(nb), 32'd12);
    for (int i = 0; i < 16; i++) begin
      idle_inputs();
      read_en = 1'b1;
      address = 4'(i);
      cyc();
      check_eq("t1_rd_valid", 32'(a_valid), 32'd1);
      check_eq("t1_rd_data",  32'(a_data_out), 32'h0000);
    end

    // 2. Byte enables.
    wr(4'd5, 16'hA5C3, 2'b11);
    wr(4'd5, 16'h1200, 2'b10);
    idle_inputs();
    read_en = 1'b1;
    address = 4'd5;
    cyc();
    check_eq("t2_a_rd5", 32'(a_data_out), 32'h12C3);
    idle_inputs();
    cyc();
    check_eq("t2_b_rd5", 32'(b_data_out), 32'h12C3);

    // 3. Read during write at addr 3.
    wr(4'd3, 16'h1111, 2'b11);
    idle_inputs();
    write_en = 1'b1;
    read_en  = 1'b1;
    address  = 4'd3;
    data_in  = 16'h2222;
    byte_en  = 2'b01;
    cyc();
    check_eq("t3_a_rdw_old", 32'(a_data_out), 32'h1111);
    idle_inputs();
    read_en = 1'b1;
    address = 4'd3;
    cyc();
    check_eq("t3_b_rdw_new", 32'(b_data_out), 32'h1122);
    check_eq("t3_a_after",   32'(a_data_out), 32'h1122);
    idle_inputs();
    cyc();
    check_eq("t3_b_after",   32'(b_data_out), 32'h1122);

    // 4. Back-to-back reads through the output register.
    for (int i = 0; i < 4; i++) wr(4'(i), 16'h1000 + 16'(i), 2'b11);
    for (int k = 0; k < 6; k++) begin
      idle_inputs();
      read_en = (k < 4);
      address = 4'(k);
      cyc();
      check_eq("t4_b_valid", 32'(b_valid), 32'(k >= 1 && k <= 4));
      if (k >= 1 && k <= 4) check_eq("t4_b_data", 32'(b_data_out), 32'h1000 + 32'(k - 1));
    end

    // 5. clear_req beats a same-cycle write; writes during the sweep are ignored.
    idle_inputs();
    clear_req = 1'b1;
    write_en  = 1'b1;
    address   = 4'd7;
    data_in   = 16'hFFFF;
    byte_en   = 2'b11;
    cyc();
    clear_req = 1'b0;
    data_in   = 16'hBEEF;
    count_busy(na, nb);
    check_eq("t5_busy_len_a", 32'(na), 32'd16);
    idle_inputs();
    read_en = 1'b1;
    address = 4'd7;
    cyc();
    check_eq("t5_a_rd7", 32'(a_data_out), 32'h0000);

    // 6. Reset in the middle of a sweep restarts it; out-of-range reads.
    idle_inputs();
    clear_req = 1'b1;
    cyc();
    clear_req = 1'b0;
    repeat (9) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    count_busy(na, nb);
    check_eq("t6_busy_len_a", 32'(na), 32'd16);
    check_eq("t6_busy_len_b", 32'(nb), 32'd12);
    for (int i = 12; i < 16; i++) begin
      idle_inputs();
      read_en = 1'b1;
      address = 4'(i);
      cyc();
      idle_inputs();
      cyc();
      check_eq("t6_b_oor_valid", 32'(b_valid),    32'd1);
      check_eq("t6_b_oor_data",  32'(b_data_out), 32'h5A5A);
    end

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      rst       = ($urandom_range(0, 149) == 0);
      clear_req = ($urandom_range(0, 39) == 0);
      write_en  = 1'($urandom_range(0, 1));
      read_en   = 1'($urandom_range(0, 1));
      address   = 4'($urandom_range(0, 15));
      byte_en   = 2'($urandom_range(0, 3));
      data_in   = 16'($urandom);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
